matrix_result_tx_fsm: RTL and testbench
=======================================

// Module: matrix_result_tx_fsm
// PURPOSE
// - Transmit-side frame builder for the UART matrix-vector link; the counterpart of the Rx frame decoder.
// - On start, reads N result words from the result RAM and serialises one frame through the byte UART TX:
//   START, LEN, CMD, {D_hi, D_lo} x N, END.
// - Sits between the matrix-vector product engine/result RAM and the UART transmitter.
// PARAMETERS
// - DATA_W     8      UART byte width
// - RES_W      16     result word width; sent as 2 bytes, MSB first (RES_W == 2*DATA_W)
// - MAX_LEN    16     max result elements per frame
// - ADDR_W     4      result RAM address width; covers addresses 0..MAX_LEN-1
// - START_BYTE 8'hFE  frame start marker
// - END_BYTE   8'hEF  frame end marker
// PORTS
// - clk       in   1                clock, rising edge
// - reset     in   1                asynchronous, active-high reset
// - start     in   1                1-cycle request to send a frame; sampled only in IDLE
// - n_elems   in   $clog2(MAX_LEN+1) element count N, sampled with start
// - cmd       in   DATA_W           command byte, sampled with start
// - rd_en     out  1                result RAM read enable
// - rd_addr   out  ADDR_W           result RAM address
// - rd_data   in   RES_W            RAM data; valid 1 cycle after rd_en/rd_addr are registered
// - tx_ready  in   1                UART TX idle; can accept a byte
// - tx_send   out  1                1-cycle strobe; UART latches tx_byte
// - tx_byte   out  DATA_W           byte to send
// - busy      out  1                frame in progress
// - done      out  1                1-cycle pulse when the frame is complete
// BEHAVIOUR
// - Register all outputs. Reset values: rd_en=0, rd_addr=0, tx_send=0, tx_byte=0, busy=0, done=0; state=IDLE, idx=0.
// - States: IDLE, S_START, S_LEN, S_CMD, FETCH, RD_WAIT, LATCH, S_HI, S_LO, S_END, HOLD.
// - IDLE, start=1: capture n_elems into len_q and cmd into cmd_q; set idx=0, busy=1; go to S_START.
//   - In IDLE, start=0 leaves state unchanged.
//   - start in any other state is ignored; sampled values are held for the whole frame.
// - Send-state rule (S_START/S_LEN/S_CMD/S_HI/S_LO/S_END):
//   - Wait while tx_ready=0.
//   - When tx_ready=1: tx_send<=1, tx_byte<=value, record the return state, go to HOLD.
//   - Never 2 strobes for one byte.
// - HOLD: tx_send<=0. Wait until tx_ready=0 (UART accepted), then go to the recorded next state.
// - Byte values:
//   - S_LEN sends len_q zero-extended to DATA_W.
//   - S_HI sends word_q[RES_W-1:DATA_W]; S_LO sends word_q[DATA_W-1:0].
// - Sequence: S_START -> S_LEN -> S_CMD -> (len_q==0 ? S_END : FETCH).
// - Data path:
//   - FETCH: rd_en<=1, rd_addr<=idx.
//   - RD_WAIT: rd_en<=0.
//   - LATCH: word_q<=rd_data.
//   - S_HI -> S_LO.
//   - After S_LO: idx<=idx+1; if idx+1==len_q go to S_END, else FETCH.
// - After S_END is accepted (HOLD sees tx_ready=0): return to IDLE, busy<=0, done<=1 for 1 cycle.
//   - start is accepted again from the cycle done is high.
// - n_elems>MAX_LEN: saturate len_q to MAX_LEN; LEN byte = MAX_LEN.
// - Exactly 2*N+4 tx_send strobes per frame; rd_addr runs 0..N-1 with no wrap.
// - Reset asserted mid-frame: immediate return to reset values; no further strobes; no done.
// TESTING
// - Idle, start with N=2, cmd=8'h05, RAM[0]=16'h1234, RAM[1]=16'hABCD, tx_ready model drops 1 cycle after tx_send
//   -> bytes FE,02,05,12,34,AB,CD,EF; 1 done pulse; busy low after.
// - N=0, cmd=8'h02 -> bytes FE,00,02,EF; rd_en never asserted.
// - tx_ready held low 50 cycles before each byte -> same byte stream; exactly 1 tx_send per byte.
// - start pulsed again mid-frame with N=5 -> ignored; frame LEN stays 02; total strobes = 8.
// - N=20 with MAX_LEN=16 -> LEN byte 8'h10; 16 reads at addresses 0..15; 36 strobes.
// - reset high during the 3rd data byte -> all outputs 0 next edge; no done; new start afterwards gives a clean full frame.

Source files
------------

// File: rtl/matrix_result_tx_fsm.sv
// Transmit-side frame builder: reads N result words from the result RAM and
// serialises START, LEN, CMD, {D_hi, D_lo} x N, END through a byte UART TX.
module matrix_result_tx_fsm #(
  parameter int                DATA_W     = 8,
  parameter int                RES_W      = 16,
  parameter int                MAX_LEN    = 16,
  parameter int                ADDR_W     = 4,
  parameter logic [DATA_W-1:0] START_BYTE = 8'hFE,
  parameter logic [DATA_W-1:0] END_BYTE   = 8'hEF,
  localparam int               CNT_W      = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_elems,
  input  logic [DATA_W-1:0] cmd,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RES_W-1:0]  rd_data,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_byte,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, S_START, S_LEN, S_CMD, FETCH, RD_WAIT, LATCH, S_HI, S_LO, S_END, HOLD
  } state_t;

  state_t              state, state_d, ret_q, ret_d;
  logic [CNT_W-1:0]    len_q, len_d, idx, idx_d, idx_inc;
  logic [DATA_W-1:0]   cmd_q, cmd_d, tx_byte_d, send_val;
  logic [RES_W-1:0]    word_q, word_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                rd_en_d, tx_send_d, busy_d, done_d, is_send;
  state_t              send_next;

  assign idx_inc = idx + CNT_W'(1);

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state;
    ret_d     = ret_q;
    len_d     = len_q;
    cmd_d     = cmd_q;
    idx_d     = idx;
    word_d    = word_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    tx_send_d = 1'b0;
    tx_byte_d = tx_byte;
    busy_d    = busy;
    done_d    = 1'b0;
    is_send   = 1'b0;
    send_val  = '0;
    send_next = IDLE;

    case (state)
      IDLE: begin
        if (start) begin
          len_d   = (n_elems > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : n_elems;
          cmd_d   = cmd;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        is_send   = 1'b1;
        send_val  = START_BYTE;
        send_next = S_LEN;
      end
      S_LEN: begin
        is_send   = 1'b1;
        send_val  = DATA_W'(len_q);
        send_next = S_CMD;
      end
      S_CMD: begin
        is_send   = 1'b1;
        send_val  = cmd_q;
        send_next = (len_q == '0) ? S_END : FETCH;
      end
      FETCH: begin
        rd_en_d   = 1'b1;
        rd_addr_d = ADDR_W'(idx);
        state_d   = RD_WAIT;
      end
      RD_WAIT: state_d = LATCH;
      LATCH: begin
        word_d  = rd_data;
        state_d = S_HI;
      end
      S_HI: begin
        is_send   = 1'b1;
        send_val  = word_q[RES_W-1:DATA_W];
        send_next = S_LO;
      end
      S_LO: begin
        is_send   = 1'b1;
        send_val  = word_q[DATA_W-1:0];
        send_next = (idx_inc == len_q) ? S_END : FETCH;
        if (tx_ready) idx_d = idx_inc;
      end
      S_END: begin
        is_send   = 1'b1;
        send_val  = END_BYTE;
        send_next = IDLE;
      end
      HOLD: begin
        // A low tx_ready means the UART has taken the byte.
        if (!tx_ready) begin
          state_d = ret_q;
          if (ret_q == IDLE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (is_send && tx_ready) begin
      tx_send_d = 1'b1;
      tx_byte_d = send_val;
      ret_d     = send_next;
      state_d   = HOLD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ret_q   <= IDLE;
      len_q   <= '0;
      cmd_q   <= '0;
      idx     <= '0;
      word_q  <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      tx_send <= 1'b0;
      tx_byte <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      ret_q   <= ret_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      idx     <= idx_d;
      word_q  <= word_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      tx_send <= tx_send_d;
      tx_byte <= tx_byte_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_matrix_result_tx_fsm.sv
// Scoreboard bench for matrix_result_tx_fsm: a frame-level reference model
// queues expected bytes/addresses, a negedge monitor pops and compares them.
module tb_matrix_result_tx_fsm;
  localparam int DATA_W = 8, RES_W = 16, MAX_LEN = 16, ADDR_W = 4;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [CNT_W-1:0]  n_elems = '0;
  logic [DATA_W-1:0] cmd = '0;
  logic              rd_en, tx_send, busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [RES_W-1:0]  rd_data = '0;
  logic              tx_ready = 1'b1;
  logic [DATA_W-1:0] tx_byte;

  always #5 clk = ~clk;

  matrix_result_tx_fsm dut (
    .clk(clk), .reset(reset), .start(start), .n_elems(n_elems), .cmd(cmd),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tx_ready(tx_ready),
    .tx_send(tx_send), .tx_byte(tx_byte), .busy(busy), .done(done)
  );

  // Result RAM: one-cycle read latency.
  logic [RES_W-1:0] ram [MAX_LEN];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // UART model: takes the byte one edge after the strobe, then stays busy.
  int lat_mode = 0;  // 0: one cycle, 1: random 1..4, 2: fifty cycles
  int hold_cnt = 0;
  always @(posedge clk) begin
    if (hold_cnt > 0) begin
      if (hold_cnt == 1) tx_ready <= 1'b1;
      hold_cnt <= hold_cnt - 1;
    end else if (tx_send) begin
      tx_ready <= 1'b0;
      hold_cnt <= (lat_mode == 2) ? 50 : (lat_mode == 1) ? int'($urandom_range(1, 4)) : 1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  int strobe_cnt = 0, done_cnt = 0, rd_cnt = 0;
  logic [DATA_W-1:0] exp_bytes [$];
  logic [ADDR_W-1:0] exp_addrs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_send) begin
      strobe_cnt++;
      if (exp_bytes.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL extra_strobe: got byte %0h expected none", tx_byte);
      end else check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_bytes.pop_front()});
    end
    if (rd_en) begin
      rd_cnt++;
      if (exp_addrs.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL extra_read: got addr %0d expected none", rd_addr);
      end else check("rd_addr", {28'h0, rd_addr}, {28'h0, exp_addrs.pop_front()});
    end
    if (done) done_cnt++;
  end

  // Frame-level reference: what a frame for (n, c) must look like on the wire.
  task automatic expect_frame(input int n, input logic [7:0] c, output int eff);
    eff = (n > MAX_LEN) ? MAX_LEN : n;
    exp_bytes.push_back(8'hFE);
    exp_bytes.push_back(8'(eff));
    exp_bytes.push_back(c);
    for (int i = 0; i < eff; i++) begin
      exp_bytes.push_back(ram[i][15:8]);
      exp_bytes.push_back(ram[i][7:0]);
      exp_addrs.push_back(4'(i));
    end
    exp_bytes.push_back(8'hEF);
  endtask

  task automatic pulse_start(input int n, input logic [7:0] c);
    @(negedge clk);
    n_elems = CNT_W'(n); cmd = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic [7:0] c, input int mode,
                           input bit rnd_ram, input bit poke);
    int  eff;
    bit  seen;
    lat_mode = mode;
    if (rnd_ram) for (int i = 0; i < MAX_LEN; i++) ram[i] = RES_W'($urandom);
    expect_frame(n, c, eff);
    strobe_cnt = 0; done_cnt = 0; rd_cnt = 0;
    pulse_start(n, c);
    if (poke) begin
      repeat (6) @(negedge clk);
      pulse_start(5, 8'hAA);
    end
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'h0, seen}, 32'd1);
    check("busy_at_done", {31'h0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("strobes", strobe_cnt, 2 * eff + 4);
    check("reads", rd_cnt, eff);
    check("done_pulses", done_cnt, 1);
    check("bytes_left", exp_bytes.size(), 0);
    check("busy_after", {31'h0, busy}, 32'd0);
    exp_bytes.delete();
    exp_addrs.delete();
  endtask

  initial begin
    int s0;
    bit hit;
    int dummy;
    repeat (2) @(negedge clk);
    check("reset_outs", {16'h0, rd_en, rd_addr, tx_send, tx_byte, busy, done}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_outs", {16'h0, rd_en, rd_addr, tx_send, tx_byte, busy, done}, 32'd0);

    ram[0] = 16'h1234; ram[1] = 16'hABCD;
    run_frame(2, 8'h05, 0, 1'b0, 1'b0);
    run_frame(0, 8'h02, 0, 1'b1, 1'b0);
    run_frame(2, 8'h05, 2, 1'b1, 1'b0);
    run_frame(2, 8'h05, 1, 1'b1, 1'b1);
    run_frame(20, 8'h33, 0, 1'b1, 1'b0);
    run_frame(16, 8'h44, 1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      run_frame(int'($urandom_range(0, 31)), 8'($urandom), int'($urandom_range(0, 1)), 1'b1, 1'b0);

    // Reset during the third data byte.
    lat_mode = 0;
    for (int i = 0; i < MAX_LEN; i++) ram[i] = RES_W'($urandom);
    expect_frame(4, 8'h77, dummy);
    strobe_cnt = 0; done_cnt = 0; rd_cnt = 0;
    pulse_start(4, 8'h77);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt >= 6) hit = 1'b1;
    end
    check("reached_3rd_data", {31'h0, hit}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outs", {16'h0, rd_en, rd_addr, tx_send, tx_byte, busy, done}, 32'd0);
    exp_bytes.delete();
    exp_addrs.delete();
    s0 = strobe_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("no_strobe_after_reset", strobe_cnt, s0);
    check("no_done_after_reset", done_cnt, 0);
    run_frame(3, 8'h99, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
